// File: rtl/serial_cla_subtractor_pkg.sv
// Shared types and sizing helpers for the serial CLA subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_GROUP = 4;

    function automatic int ngroups(input int width, input int group);
        return width / group;
    endfunction

    // Group index needs at least one bit even when a single group covers the word.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_cla_subtractor_cla_group_slice.sv
// Combinational GROUP-bit carry-lookahead adder, zero latency, no flow control.
// Carries are flattened sum-of-products terms of generate/propagate, plus group P/G.
module cla_group_slice #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             c_out,
    output logic             p_grp,
    output logic             g_grp
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   gx;
    logic [GROUP:0]   c;

    assign p  = a ^ b;
    assign g  = a & b;
    // gx[0] is the incoming carry; gx[j] for j>0 is generate of bit j-1.
    assign gx = {g, c_in};

    always_comb begin
        logic term;
        c     = '0;
        g_grp = 1'b0;
        c[0]  = c_in;
        for (int i = 0; i < GROUP; i++) begin
            for (int j = 0; j <= i + 1; j++) begin
                term = gx[j];
                for (int k = j; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        for (int j = 1; j <= GROUP; j++) begin
            term = gx[j];
            for (int k = j; k < GROUP; k++) begin
                term = term & p[k];
            end
            g_grp = g_grp | term;
        end
    end

    assign s     = p ^ c[GROUP-1:0];
    assign c_out = c[GROUP];
    assign p_grp = &p;

endmodule

// File: rtl/serial_cla_subtractor.sv
// Serial WIDTH-bit subtractor, one GROUP slice per cycle; result NGROUPS cycles after accept,
// held in DONE until out_ready. Define SUB_OVERFLOW_EN to add the two's-complement ovf output.
module serial_cla_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NGROUPS = ngroups(WIDTH, GROUP);
    localparam int IDXW    = idx_width(NGROUPS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NGROUPS - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              borrow_q, borrow_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic [GROUP-1:0]  a_slice;
    logic [GROUP-1:0]  nb_slice;
    logic [GROUP-1:0]  sum;
    logic              c_out;
    logic              grp_p;
    logic              grp_g;
    logic              unused_pg;

    assign in_ready  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign b_out     = bout_q;

    assign a_slice   = a_q[int'(idx_q)*GROUP +: GROUP];
    assign nb_slice  = ~b_q[int'(idx_q)*GROUP +: GROUP];
    // Subtraction as A + ~B + ~borrow: a carry out of the slice means no borrow.
    cla_group_slice #(.GROUP(GROUP)) u_slice (
        .a     (a_slice),
        .b     (nb_slice),
        .c_in  (~borrow_q),
        .s     (sum),
        .c_out (c_out),
        .p_grp (grp_p),
        .g_grp (grp_g)
    );
    assign unused_pg = grp_p ^ grp_g;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: ;
            BUSY: begin
                diff_d[int'(idx_q)*GROUP +: GROUP] = sum;
                borrow_d = ~c_out;
                if (idx_q == LAST_IDX) begin
                    bout_d  = ~c_out;
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (sum[GROUP-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // accept can only fire in IDLE or DONE, never while BUSY.
        if (accept) begin
            a_d      = minuend;
            b_d      = subtrahend;
            borrow_d = b_in;
            idx_d    = '0;
            state_d  = BUSY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef SUB_OVERFLOW_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_cla_subtractor.sv
// Bench for serial_cla_subtractor: directed cases plus randomized traffic against an arithmetic model.
module tb_serial_cla_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] minuend = '0;
    logic [W-1:0] subtrahend = '0;
    logic         b_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         b_out;
`ifdef SUB_OVERFLOW_EN
    logic         ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic rand_rdy = 1'b0;

    typedef struct packed {
        logic         ovf;
        logic         bo;
        logic [W-1:0] d;
    } res_t;

    res_t exp_q[$];

    serial_cla_subtractor dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .b_in       (b_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .b_out      (b_out)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        res_t r;
        logic [W:0] full;
        full = {1'b0, a} - {1'b0, b} - (W+1)'(bi);
        r.d   = full[W-1:0];
        r.bo  = full[W];
        r.ovf = (a[W-1] != b[W-1]) && (r.d[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expectation pushed at each accepted handshake, popped when the result is consumed.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("sb_diff", 32'(diff), 32'(exp_q[0].d));
                    check("sb_b_out", 32'(b_out), 32'(exp_q[0].bo));
`ifdef SUB_OVERFLOW_EN
                    check("sb_ovf", 32'(ovf), 32'(exp_q[0].ovf));
`endif
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(minuend, subtrahend, b_in));
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, output int waits);
        minuend    = a;
        subtrahend = b;
        b_in       = bi;
        in_valid   = 1'b1;
        waits      = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts negedges until out_valid; also counts cycles in_ready was seen high meanwhile.
    task automatic wait_result(output logic [W-1:0] d, output logic bo, output int lat, output int rdy_hi);
        lat    = 0;
        rdy_hi = 0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            lat++;
            if (in_ready) rdy_hi++;
            @(negedge clk);
        end
        if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
        d  = diff;
        bo = b_out;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        res_t         r;
        logic [W-1:0] d;
        logic         bo;
        int           lat, rdy_hi, w;

        // Pin the model against hand-computed values.
        r = model(16'h1234, 16'h0234, 1'b0);
        check("model_1234", 32'(r), 32'h0_1000);
        r = model(16'h0000, 16'h0001, 1'b0);
        check("model_borrow", 32'(r), 32'h1_FFFF);
        r = model(16'h8000, 16'h0000, 1'b1);
        check("model_ovf", 32'(r), 32'h2_7FFF);

        // Reset state.
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_b_out", 32'(b_out), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // 1: basic op, latency and in_ready low while busy.
        @(posedge clk); #1;
        send(16'h1234, 16'h0234, 1'b0, w);
        wait_result(d, bo, lat, rdy_hi);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_busy_in_ready", 32'(rdy_hi), 32'd0);
        check("t1_diff", 32'(d), 32'h1000);
        check("t1_b_out", 32'(bo), 32'd0);

        // 2: borrow through all groups.
        @(posedge clk); #1;
        send(16'h0000, 16'h0001, 1'b0, w);
        wait_result(d, bo, lat, rdy_hi);
        check("t2_diff", 32'(d), 32'hFFFF);
        check("t2_b_out", 32'(bo), 32'd1);

        // 3: overflow corners.
        @(posedge clk); #1;
        send(16'h8000, 16'h0000, 1'b1, w);
        wait_result(d, bo, lat, rdy_hi);
        check("t3a_diff", 32'(d), 32'h7FFF);
        check("t3a_b_out", 32'(bo), 32'd0);
`ifdef SUB_OVERFLOW_EN
        check("t3a_ovf", 32'(ovf), 32'd1);
`endif
        @(posedge clk); #1;
        send(16'h7FFF, 16'hFFFF, 1'b0, w);
        wait_result(d, bo, lat, rdy_hi);
        check("t3b_diff", 32'(d), 32'h8000);
        check("t3b_b_out", 32'(bo), 32'd1);
`ifdef SUB_OVERFLOW_EN
        check("t3b_ovf", 32'(ovf), 32'd1);
`endif

        // 4: back-pressure, then same-cycle accept from DONE.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h5555, 16'h1111, 1'b0, w);
        wait_result(d, bo, lat, rdy_hi);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_hold_diff", 32'(diff), 32'h4444);
            check("t4_hold_b_out", 32'(b_out), 32'd0);
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h00FF, 16'h000F, 1'b0, w);
        check("t4_same_cycle_accept", 32'(w), 32'd0);
        wait_result(d, bo, lat, rdy_hi);
        check("t4_latency", 32'(lat), 32'd4);
        check("t4_diff", 32'(d), 32'h00F0);

        // 5: inputs wiggled while busy must be ignored.
        @(posedge clk); #1;
        send(16'h4321, 16'h1234, 1'b1, w);
        minuend = 16'hFFFF; subtrahend = 16'h0000; b_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        minuend = 16'h0001; subtrahend = 16'hFFFF; b_in = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(d, bo, lat, rdy_hi);
        check("t5_diff", 32'(d), 32'h30EC);
        check("t5_b_out", 32'(bo), 32'd0);
        @(negedge clk);
        check("t5_no_extra", 32'(out_valid), 32'd0);

        // 6: reset in the middle of BUSY.
        @(posedge clk); #1;
        send(16'h1234, 16'h0001, 1'b0, w);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_diff", 32'(diff), 32'd0);
        check("t6_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send(16'hABCD, 16'h1111, 1'b0, w);
        wait_result(d, bo, lat, rdy_hi);
        check("t6_diff", 32'(d), 32'h9ABC);
        check("t6_b_out", 32'(bo), 32'd0);

        // Randomized traffic with random consumer stalls.
        @(posedge clk); #1;
        rand_rdy = 1'b1;
        for (int n = 0; n < 250; n++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 3))
                0: ;
                1: b = a;
                2: a = '0;
                default: a = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
            endcase
            send(a, b, 1'($urandom_range(0, 1)), w);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
